serial_receiver: RTL and testbench

Serial-to-parallel receiver for the token-router link, clocked on Clk_S. It deframes the single-wire S_Data stream produced by the router transmitter and checks parity. Each good frame is presented as a 55-bit word through a one-entry holding register with a valid/ready handshake to the router core. S_Data is synchronous to Clk_S (same clock domain as the transmitter), so no input synchronizer is used.

---
 rtl/serial_receiver_if.sv | 10 +
 rtl/serial_receiver.sv | 57 +++++
 tb/tb_serial_receiver.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_receiver_if.sv
// serial_receiver_if: receive-side handshake bundle between deframer and router core
interface serial_receiver_if #(parameter int DATA_W = 55);
  logic [DATA_W-1:0] RX_Data;
  logic              RX_Data_Valid;
  logic              RX_Ready;
  logic              RX_Parity_Err;
  logic              RX_Overrun;
  modport master (output RX_Data, RX_Data_Valid, RX_Parity_Err, RX_Overrun, input RX_Ready);
  modport slave  (input RX_Data, RX_Data_Valid, RX_Parity_Err, RX_Overrun, output RX_Ready);
endinterface

// File: rtl/serial_receiver.sv
// serial_receiver: deframes a start/MSB-first payload/even-parity stream into a one-entry valid/ready holding register
module serial_receiver #(
  parameter int DATA_W = 55,
  parameter int CNT_W  = 6
) (
  input  logic             Clk_S,
  input  logic             Rst,
  input  logic             S_Data,
  serial_receiver_if.master rx
);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q, data_q;
  logic              valid_q, perr_q, ovr_q;
  logic              par_ok, drain, last;
  assign par_ok = (^shift_q) == S_Data;
  assign drain  = valid_q & rx.RX_Ready;
  assign last   = cnt_q == CNT_W'(DATA_W - 1);
  always_ff @(posedge Clk_S or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (drain) valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (S_Data) begin
          state_q <= SHIFT;
          cnt_q   <= '0;
        end
      end else if (state_q == SHIFT) begin
        shift_q <= {shift_q[DATA_W-2:0], S_Data};
        cnt_q   <= cnt_q + 1'b1;
        if (last) state_q <= PARITY;
      end else begin
        state_q <= IDLE;
        // a drain on this edge frees the slot, so the new word may replace it
        if (!par_ok) perr_q <= 1'b1;
        else if (!valid_q || rx.RX_Ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else ovr_q <= 1'b1;
      end
    end
  end
  assign rx.RX_Data       = data_q;
  assign rx.RX_Data_Valid = valid_q;
  assign rx.RX_Parity_Err = perr_q;
  assign rx.RX_Overrun    = ovr_q;
endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed and random frames checked against a frame-level holding-register model
module tb_serial_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_data = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rmode = 1;
  logic [54:0] exp_data = '0;
  logic        exp_valid = 1'b0, exp_perr = 1'b0, exp_ovr = 1'b0;
  serial_receiver_if #(.DATA_W(55)) rx ();
  serial_receiver #(.DATA_W(55), .CNT_W(6)) dut (.Clk_S(clk), .Rst(rst), .S_Data(s_data), .rx(rx));
  always #5 clk = ~clk;
  task automatic check_outputs(input string tag);
    checks++;
    assert (rx.RX_Data_Valid === exp_valid) else begin
      errors++;
      $error("FAIL %s valid: got %0b exp %0b", tag, rx.RX_Data_Valid, exp_valid);
    end
    checks++;
    assert (rx.RX_Data === exp_data) else begin
      errors++;
      $error("FAIL %s data: got %h exp %h", tag, rx.RX_Data, exp_data);
    end
    checks++;
    assert (rx.RX_Parity_Err === exp_perr) else begin
      errors++;
      $error("FAIL %s parity_err: got %0b exp %0b", tag, rx.RX_Parity_Err, exp_perr);
    end
    checks++;
    assert (rx.RX_Overrun === exp_ovr) else begin
      errors++;
      $error("FAIL %s overrun: got %0b exp %0b", tag, rx.RX_Overrun, exp_ovr);
    end
  endtask
  // one clock: drive line/ready, advance the model by any frame ending on this edge, then check
  task automatic tick(input logic sd, input bit done, input bit good, input logic [54:0] word, input string tag);
    logic rdy;
    rdy = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(done);
    s_data = sd;
    rx.RX_Ready = rdy;
    @(posedge clk);
    exp_perr = done && !good;
    exp_ovr  = 1'b0;
    if (done && good) begin
      if (!exp_valid || rdy) begin
        exp_data  = word;
        exp_valid = 1'b1;
      end else exp_ovr = 1'b1;
    end else if (exp_valid && rdy) exp_valid = 1'b0;
    #1;
    check_outputs(tag);
  endtask
  task automatic send(input logic [54:0] d, input bit bad, input string tag);
    tick(1'b1, 0, 0, d, tag);
    for (int i = 54; i >= 0; i--) tick(d[i], 0, 0, d, tag);
    tick((^d) ^ bad, 1, !bad, d, tag);
  endtask
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, '0, tag);
  endtask
  task automatic reset_now(input string tag);
    rst = 1'b1;
    s_data = 1'b1;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_perr  = 1'b0;
    exp_ovr   = 1'b0;
    #1;
    check_outputs(tag);
    repeat (2) @(posedge clk);
    #1;
    check_outputs(tag);
    rst = 1'b0;
  endtask
  initial begin
    rx.RX_Ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("por");
    rst = 1'b0;
    idle(2, "idle0");
    rmode = 1;
    send(55'h2A_AAAA_AAAA_AAAA, 0, "single");
    idle(2, "single_drain");
    send(55'h1, 1, "parity_err");
    idle(2, "after_perr");
    rmode = 0;
    send(55'h12345, 0, "bp_f1");
    send(55'h6789A, 0, "bp_f2");
    idle(3, "bp_hold");
    rmode = 1;
    idle(2, "bp_release");
    rmode = 0;
    send(55'h0F0F_0F0F_0F0F, 0, "dl_a");
    rmode = 3;
    send(55'h3C_3C3C_3C3C_3C3C, 0, "dl_b");
    rmode = 0;
    idle(2, "dl_hold");
    tick(1'b1, 0, 0, '0, "mf_start");
    for (int i = 54; i >= 24; i--) tick(1'b1, 0, 0, '0, "mf_bits");
    #2;
    reset_now("mid_reset");
    rmode = 1;
    send(55'h7F_FFFF_FFFF_FFFF, 0, "post_reset");
    idle(2, "post_reset_idle");
    rmode = 2;
    for (int f = 0; f < 40; f++) begin
      logic [54:0] w;
      w = {$urandom, $urandom};
      send(w, $urandom_range(0, 3) == 0, "rand");
      idle($urandom_range(0, 2), "rand_gap");
    end
    rmode = 1;
    idle(3, "final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
